// File: rtl/pwm_deadtime_ctrl_pkg.sv
// rtl/pwm_deadtime_ctrl_pkg.sv - shared state encoding and dead-time floor for the PWM dead-time controller
package pwm_deadtime_ctrl_pkg;

   // Smallest dead time a downstream generator can load (it loads deadtime-1)
   localparam int DT_MIN = 1;

   typedef enum logic [2:0] {
      IDLE,
      STARTUP,
      RUN,
      SHUTDOWN
`ifdef FAULT_INPUT_EN
      , FAULT
`endif
   } state_e;

endpackage

// File: rtl/dt_shadow_bank.sv
// rtl/dt_shadow_bank.sv - shadow/active dead-time banks with zero clamp and tear-free transfer
module dt_shadow_bank
   import pwm_deadtime_ctrl_pkg::*;
#(
   parameter int N_CHANNELS = 3,
   parameter int DT_WIDTH   = 16,
   parameter int DEFAULT_DT = 10,
   parameter int CH_W       = 2
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           cfg_valid_i,
   input  logic [CH_W-1:0]                cfg_channel_i,
   input  logic [DT_WIDTH-1:0]            cfg_deadtime_i,
   input  logic                           commit_i,
   input  logic                           sync_i,
   input  logic                           sync_mode_i,
   input  logic                           idle_mode_i,
   input  logic                           flush_i,
   input  logic                           err_clear_i,
   output logic                           cfg_ready_o,
   output logic [N_CHANNELS*DT_WIDTH-1:0] active_o,
   output logic                           update_done_o,
   output logic                           cfg_error_o
);

   localparam logic [DT_WIDTH-1:0] DT_FLOOR = DT_WIDTH'(DT_MIN);
   localparam logic [DT_WIDTH-1:0] DT_RST   = (DEFAULT_DT < DT_MIN) ? DT_FLOOR : DT_WIDTH'(DEFAULT_DT);

   logic [N_CHANNELS-1:0][DT_WIDTH-1:0] shadow_q, shadow_d;
   logic [N_CHANNELS-1:0][DT_WIDTH-1:0] active_q, active_d;
   logic pending_q, pending_d;
   logic update_done_q, update_done_d;
   logic cfg_error_q, cfg_error_d;
   logic wr, in_range, transfer;

   // The shadow bank is locked from commit until the transfer has happened
   assign cfg_ready_o   = ~pending_q;
   assign wr            = cfg_valid_i & ~pending_q;
   assign in_range      = int'(cfg_channel_i) < N_CHANNELS;
   assign transfer      = pending_q & ((sync_mode_i & sync_i) | idle_mode_i) & ~flush_i;
   assign active_o      = active_q;
   assign update_done_o = update_done_q;
   assign cfg_error_o   = cfg_error_q;

   // Next-state for shadow writes (zero clamped), bank copy, pending and error flags
   always_comb begin
      shadow_d      = shadow_q;
      active_d      = active_q;
      pending_d     = (pending_q & ~transfer) | commit_i;
      update_done_d = transfer;
      cfg_error_d   = err_clear_i ? 1'b0 : cfg_error_q;
      for (int k = 0; k < N_CHANNELS; k++) begin
         if (wr && in_range && int'(cfg_channel_i) == k) begin
            shadow_d[k] = (cfg_deadtime_i == '0) ? DT_FLOOR : cfg_deadtime_i;
         end
      end
      if (wr && !in_range) begin
         cfg_error_d = 1'b1;
      end
      if (transfer) begin
         active_d = shadow_q;
      end
      if (flush_i) begin
         pending_d = 1'b0;
      end
   end

   // Bank and flag registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shadow_q      <= {N_CHANNELS{DT_RST}};
         active_q      <= {N_CHANNELS{DT_RST}};
         pending_q     <= 1'b0;
         update_done_q <= 1'b0;
         cfg_error_q   <= 1'b0;
      end else begin
         shadow_q      <= shadow_d;
         active_q      <= active_d;
         pending_q     <= pending_d;
         update_done_q <= update_done_d;
         cfg_error_q   <= cfg_error_d;
      end
   end

endmodule

// File: rtl/pwm_deadtime_controller.sv
// rtl/pwm_deadtime_controller.sv - staggered-enable dead-time controller FSM; optional fault input under FAULT_INPUT_EN
module pwm_deadtime_controller
   import pwm_deadtime_ctrl_pkg::*;
#(
   parameter int N_CHANNELS  = 3,
   parameter int DT_WIDTH    = 16,
   parameter int STARTUP_GAP = 8,
   parameter int DEFAULT_DT  = 10
) (
   input  logic                                               clock,
   input  logic                                               reset,
   input  logic                                               start,
   input  logic                                               stop,
   input  logic                                               sync,
`ifdef FAULT_INPUT_EN
   input  logic                                               fault,
   input  logic                                               fault_clear,
`endif
   input  logic                                               cfg_valid,
   output logic                                               cfg_ready,
   input  logic [((N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1)-1:0] cfg_channel,
   input  logic [DT_WIDTH-1:0]                                cfg_deadtime,
   input  logic                                               commit,
   output logic [N_CHANNELS*DT_WIDTH-1:0]                     deadtime_out,
   output logic [N_CHANNELS-1:0]                              chan_enable,
   output logic                                               update_done,
   output logic                                               cfg_error
);

   localparam int CH_W  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
   localparam int IDX_W = $clog2(N_CHANNELS + 1);
   localparam int GAP_W = $clog2(STARTUP_GAP + 1);

   state_e                state_q, state_d;
   logic [N_CHANNELS-1:0] en_q, en_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [GAP_W-1:0]      cnt_q, cnt_d;
   logic                  flush;

`ifdef FAULT_INPUT_EN
   assign flush       = fault;
   assign chan_enable = en_q & {N_CHANNELS{~fault}};
`else
   assign flush       = 1'b0;
   assign chan_enable = en_q;
`endif

   // Next-state: staggered enable on start, immediate stop in STARTUP, sync-aligned stop in RUN
   always_comb begin
      state_d = state_q;
      en_d    = en_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               en_d    = N_CHANNELS'(1);
               idx_d   = IDX_W'(1);
               cnt_d   = '0;
               state_d = (N_CHANNELS == 1) ? RUN : STARTUP;
            end
         end
         STARTUP: begin
            if (stop) begin
               en_d    = '0;
               state_d = IDLE;
            end else if (cnt_q == GAP_W'(STARTUP_GAP - 1)) begin
               en_d  = en_q | (N_CHANNELS'(1) << idx_q);
               idx_d = idx_q + IDX_W'(1);
               cnt_d = '0;
               if (idx_q == IDX_W'(N_CHANNELS - 1)) begin
                  state_d = RUN;
               end
            end else begin
               cnt_d = cnt_q + GAP_W'(1);
            end
         end
         RUN: begin
            if (stop) begin
               state_d = SHUTDOWN;
            end
         end
         SHUTDOWN: begin
            if (sync) begin
               en_d    = '0;
               state_d = IDLE;
            end
         end
`ifdef FAULT_INPUT_EN
         FAULT: begin
            if (fault_clear && !fault) begin
               state_d = IDLE;
            end
         end
`endif
         default: begin
            en_d    = '0;
            state_d = IDLE;
         end
      endcase
`ifdef FAULT_INPUT_EN
      if (fault) begin
         en_d    = '0;
         state_d = FAULT;
      end
`endif
   end

   // FSM, enable and stagger-counter registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         en_q    <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   dt_shadow_bank #(
      .N_CHANNELS (N_CHANNELS),
      .DT_WIDTH   (DT_WIDTH),
      .DEFAULT_DT (DEFAULT_DT),
      .CH_W       (CH_W)
   ) u_bank (
      .clock          (clock),
      .reset          (reset),
      .cfg_valid_i    (cfg_valid),
      .cfg_channel_i  (cfg_channel),
      .cfg_deadtime_i (cfg_deadtime),
      .commit_i       (commit),
      .sync_i         (sync),
      .sync_mode_i    (state_q == STARTUP || state_q == RUN || state_q == SHUTDOWN),
      .idle_mode_i    (state_q == IDLE),
      .flush_i        (flush),
      .err_clear_i    (start),
      .cfg_ready_o    (cfg_ready),
      .active_o       (deadtime_out),
      .update_done_o  (update_done),
      .cfg_error_o    (cfg_error)
   );

endmodule

// File: doc/pwm_deadtime_controller.md
PWM_DEADTIME_CONTROLLER -- requirements
Module: pwm_deadtime_controller

Interface
REQ-001 SHALL have parameter N_CHANNELS, default 3, number of dead-time channels (1..16).
REQ-002 SHALL have parameter DT_WIDTH, default 16, dead-time word width in clock cycles.
REQ-003 SHALL have parameter STARTUP_GAP, default 8, cycles between successive channel enables at startup (>=1).
REQ-004 SHALL have parameter DEFAULT_DT, default 10, dead time loaded at reset.
REQ-005 SHALL have port clock, input, 1: single clock.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: one-cycle pulse that begins the staggered enable sequence.
REQ-008 SHALL have port stop, input, 1: one-cycle pulse that requests shutdown.
REQ-009 SHALL have port sync, input, 1: PWM period-boundary pulse.
REQ-010 SHALL have port cfg_valid, input, 1: config write request.
REQ-011 SHALL have port cfg_ready, output, 1: config write accepted when high together with cfg_valid.
REQ-012 SHALL have port cfg_channel, input, $clog2(N_CHANNELS) (min 1): target channel.
REQ-013 SHALL have port cfg_deadtime, input, DT_WIDTH: new dead time.
REQ-014 SHALL have port commit, input, 1: pulse that marks the shadow bank for transfer.
REQ-015 SHALL have port deadtime_out, output, N_CHANNELS*DT_WIDTH: active dead time per channel, with channel k at bits [k*DT_WIDTH +: DT_WIDTH].
REQ-016 SHALL have port chan_enable, output, N_CHANNELS: dead-time insertion enable per channel.
REQ-017 SHALL have port update_done, output, 1: one-cycle pulse after each active-bank transfer.
REQ-018 SHALL have port cfg_error, output, 1: sticky flag for an out-of-range cfg_channel; cleared by reset or start.

Function
REQ-019 SHALL implement states IDLE, STARTUP, RUN and SHUTDOWN (plus FAULT, see Configuration).
REQ-020 SHALL, in IDLE, hold chan_enable=0; start moves to STARTUP with the channel index at 0.
REQ-021 SHALL, in STARTUP, set chan_enable[0] in the cycle after start, then one further bit every STARTUP_GAP cycles, and enter RUN in the cycle the last bit is set.
REQ-022 SHALL ignore start in any state other than IDLE.
REQ-023 SHALL, on stop in STARTUP, clear all chan_enable on the next cycle and return to IDLE.
REQ-024 SHALL, on stop in RUN, enter SHUTDOWN, clear all chan_enable on the next sync, and enter IDLE in the same cycle.
REQ-025 SHALL write cfg_deadtime into shadow[cfg_channel] on each cycle in which cfg_valid and cfg_ready are both high.
REQ-026 SHALL store a cfg_deadtime value of 0 as 1, because downstream generators load deadtime-1.
REQ-027 SHALL, when cfg_channel >= N_CHANNELS, accept and drop the write and set cfg_error.
REQ-028 SHALL, on commit, set the pending flag; a write and a commit in the same cycle SHALL include that write.
REQ-029 SHALL hold cfg_ready low while pending=1, locking the shadow bank.
REQ-030 SHALL, in STARTUP, RUN or SHUTDOWN with pending=1, copy all shadows to the active bank on sync, clear pending, and pulse update_done one cycle later.
REQ-031 SHALL NOT apply a commit that coincides with sync until the following sync.
REQ-032 SHALL, in IDLE, transfer the bank in the cycle after commit without waiting for sync.
REQ-033 SHALL change deadtime_out only on a bank transfer, so it is never torn mid-period.

Reset
REQ-034 SHALL, while reset is high, asynchronously force: state IDLE, chan_enable=0, pending=0, update_done=0, cfg_error=0, cfg_ready=1, all shadow and active registers = max(DEFAULT_DT,1).

Configuration
REQ-035 SHALL, with FAULT_INPUT_EN defined, add input fault (1) and input fault_clear (1).
REQ-036 SHALL, with FAULT_INPUT_EN defined, clear chan_enable combinationally while fault is high, enter FAULT from any state, and clear pending.
REQ-037 SHALL leave FAULT for IDLE only on fault_clear with fault low.
REQ-038 SHALL, with FAULT_INPUT_EN undefined, omit the fault and fault_clear ports and the FAULT state.

Structure
REQ-039 SHALL place the state enum typedef and DT_MIN=1 in shared package pwm_deadtime_ctrl_pkg.
REQ-040 SHALL implement the shadow and active registers, the zero clamp and the transfer in sub-module dt_shadow_bank; the FSM and stagger counter live in the top module.

Verification
REQ-041 SHALL cover: start with N=3, GAP=8 -> chan_enable goes 001, 011, 111 at cycles +1, +9, +17; RUN at +17.
REQ-042 SHALL cover: in RUN, write ch1=25 and commit, then sync 40 cycles later -> deadtime_out[1] changes only at that sync; update_done one cycle later; cfg_ready low in between.
REQ-043 SHALL cover: commit and sync in the same cycle -> no transfer; transfer at the next sync.
REQ-044 SHALL cover: write of 0 to ch2 -> active value 1; write to ch3 with N=3 -> dropped and cfg_error=1.
REQ-045 SHALL cover: stop during STARTUP after 2 channels are enabled -> chan_enable=000 next cycle and IDLE; in RUN, stop -> chan_enable cleared at the next sync.
REQ-046 SHALL cover: with FAULT_INPUT_EN, fault high in RUN -> chan_enable=0 the same cycle; fault_clear while fault is high is ignored; fault_clear after fault falls -> IDLE.
